uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx.sv | 116 +++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice.
// Contents:
//   uart_rx_state_e  one-hot receiver FSM state encoding
//   UART_DATA_W      data bits per frame (8)
//   UART_STOP_BITS   stop bits per frame (1)
//   UART_CNT_W       width of the data bit counter
package uart_pkg;

  localparam int unsigned UART_DATA_W    = 8;
  localparam int unsigned UART_STOP_BITS = 1;
  localparam int unsigned UART_CNT_W     = 3;

  typedef enum logic [3:0] {
    S_RX_IDLE  = 4'b0001,
    S_RX_DATA  = 4'b0010,
    S_RX_STOP  = 4'b0100,
    S_RX_BREAK = 4'b1000
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so that an idle line is seen while coming out of reset.
// Ports:
//   clk_i     clock
//   resetn_i  asynchronous active-low reset
//   d_i       asynchronous input
//   q_o       synchronized output (2 cycles of latency)
module uart_rx_sync (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, one bit per
// clk_i cycle (no baud divider, no parity). A held-low line after a bad stop
// bit is parked in S_RX_BREAK until it returns high.
// Build option: define UART_RX_SYNC_EN to pass uart_rx_i through a 2-flop
// synchronizer (adds 2 cycles of latency); otherwise the line is sampled
// directly and must come from the clk_i domain.
// Ports:
//   clk_i           clock
//   resetn_i        asynchronous active-low reset
//   uart_rx_i       serial line, idle high
//   rx_data_o       last accepted data byte
//   rx_valid_o      rx_data_o holds an unconsumed byte
//   rx_ready_i      consumer takes the byte when high with rx_valid_o
//   rx_busy_o       FSM is not idle
//   rx_frame_err_o  one-cycle pulse on a low stop bit
//   rx_overrun_o    one-cycle pulse when a good frame is dropped
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              uart_rx_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_busy_o,
  output logic              rx_frame_err_o,
  output logic              rx_overrun_o
);

  logic rx_bit;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .d_i      (uart_rx_i),
    .q_o      (rx_bit)
  );
`else
  assign rx_bit = uart_rx_i;
`endif

  uart_rx_state_e        state_q;
  logic [UART_CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0]     shift_q;
  logic [DATA_W-1:0]     data_q;
  logic                  valid_q;
  logic                  frame_err_q;
  logic                  overrun_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= S_RX_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // Consumer handshake; a good frame below may reload valid this same cycle.
      if (valid_q && rx_ready_i) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        S_RX_IDLE: begin
          if (!rx_bit) begin
            state_q <= S_RX_DATA;
            cnt_q   <= '0;
          end
        end
        S_RX_DATA: begin
          shift_q <= {rx_bit, shift_q[DATA_W-1:1]};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == UART_CNT_W'(DATA_W - 1)) begin
            state_q <= S_RX_STOP;
          end
        end
        S_RX_STOP: begin
          if (rx_bit) begin
            state_q <= S_RX_IDLE;
            if (!valid_q || rx_ready_i) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= S_RX_BREAK;
          end
        end
        S_RX_BREAK: begin
          if (rx_bit) begin
            state_q <= S_RX_IDLE;
          end
        end
        default: begin
          state_q <= S_RX_IDLE;
        end
      endcase
    end
  end

  assign rx_data_o      = data_q;
  assign rx_valid_o     = valid_q;
  assign rx_busy_o      = (state_q != S_RX_IDLE);
  assign rx_frame_err_o = frame_err_q;
  assign rx_overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed, table-driven bench for uart_rx. Inputs are driven on the falling
// edge, outputs are checked on the falling edge. With the start bit driven at
// falling edge n0, the valid/error/overrun result is visible at n0+LAT.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 10;
`endif

  logic       clk_i = 1'b0;
  logic       resetn_i = 1'b0;
  logic       uart_rx_i = 1'b1;
  logic       rx_ready_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_busy_o;
  logic       rx_frame_err_o;
  logic       rx_overrun_o;

  uart_rx #(.DATA_W(8)) dut (
    .clk_i          (clk_i),
    .resetn_i       (resetn_i),
    .uart_rx_i      (uart_rx_i),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .rx_ready_i     (rx_ready_i),
    .rx_busy_o      (rx_busy_o),
    .rx_frame_err_o (rx_frame_err_o),
    .rx_overrun_o   (rx_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: counts high cycles of the pulses, valid rises, and any
  // change of rx_data_o while valid stays high.
  int         err_cnt = 0;
  int         ovr_cnt = 0;
  int         vrise_cnt = 0;
  int         unstable_cnt = 0;
  logic [7:0] rise_data [$];
  logic       valid_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always @(negedge clk_i) begin
    if (rx_frame_err_o) err_cnt++;
    if (rx_overrun_o) ovr_cnt++;
    if (rx_valid_o && !valid_prev) begin
      vrise_cnt++;
      rise_data.push_back(rx_data_o);
    end
    if (rx_valid_o && valid_prev && (rx_data_o != data_prev)) unstable_cnt++;
    valid_prev = rx_valid_o;
    data_prev  = rx_data_o;
  end

  // Cleared on the rising edge so it never races the falling-edge monitor.
  task automatic clr_mon();
    @(posedge clk_i);
    err_cnt   = 0;
    ovr_cnt   = 0;
    vrise_cnt = 0;
    rise_data.delete();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk_i) uart_rx_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i) uart_rx_i = d[i];
    end
    @(negedge clk_i) uart_rx_i = stop;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i) uart_rx_i = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0};
    vecs[5] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1};
    vecs[6] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0};

    // Reset state
    #12;
    chk("rst_data", 32'(rx_data_o), 32'h00);
    chk("rst_valid", 32'(rx_valid_o), 32'h0);
    chk("rst_busy", 32'(rx_busy_o), 32'h0);
    chk("rst_err", 32'(rx_frame_err_o), 32'h0);
    chk("rst_ovr", 32'(rx_overrun_o), 32'h0);
    @(negedge clk_i) resetn_i = 1'b1;
    idle(3);

    // Single frames from a drained, idle receiver
    for (int v = 0; v < 7; v++) begin
      @(negedge clk_i) begin
        uart_rx_i  = 1'b1;
        rx_ready_i = 1'b1;
      end
      idle(4);
      rx_ready_i = vecs[v].ready;
      send_frame(vecs[v].data, vecs[v].stop);
      idle(LAT - 10);
      chk($sformatf("v%0d_valid_early", v), 32'(rx_valid_o), 32'h0);
      chk($sformatf("v%0d_busy", v), 32'(rx_busy_o), 32'h1);
      idle(1);
      chk($sformatf("v%0d_valid", v), 32'(rx_valid_o), 32'(vecs[v].exp_valid));
      chk($sformatf("v%0d_data", v), 32'(rx_data_o), 32'(vecs[v].exp_data));
      chk($sformatf("v%0d_err", v), 32'(rx_frame_err_o), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_ovr", v), 32'(rx_overrun_o), 32'h0);
    end

    // 0xA5 with ready low: valid stays high and data holds
    @(negedge clk_i) rx_ready_i = 1'b1;
    idle(4);
    rx_ready_i = 1'b0;
    send_frame(8'hA5, 1'b1);
    idle(LAT - 10 + 6);
    chk("hold_valid", 32'(rx_valid_o), 32'h1);
    chk("hold_data", 32'(rx_data_o), 32'hA5);

    // Back-to-back 0x3C, 0xC3 with ready high
    @(negedge clk_i) rx_ready_i = 1'b1;
    idle(4);
    clr_mon();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(LAT + 2);
    chk("b2b_count", 32'(vrise_cnt), 32'd2);
    chk("b2b_first", 32'(rise_data.size() > 0 ? rise_data[0] : 8'hxx), 32'h3C);
    chk("b2b_second", 32'(rise_data.size() > 1 ? rise_data[1] : 8'hxx), 32'hC3);
    chk("b2b_err", 32'(err_cnt), 32'd0);
    chk("b2b_ovr", 32'(ovr_cnt), 32'd0);

    // 0x55 with a low stop bit, line held low 5 more cycles
    clr_mon();
    send_frame(8'h55, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i) uart_rx_i = 1'b0;
      chk($sformatf("brk_busy%0d", i), 32'(rx_busy_o), 32'h1);
    end
    @(negedge clk_i) uart_rx_i = 1'b1;
    idle(LAT - 10);
    chk("brk_busy_hold", 32'(rx_busy_o), 32'h1);
    idle(1);
    chk("brk_busy_clr", 32'(rx_busy_o), 32'h0);
    chk("brk_err_cnt", 32'(err_cnt), 32'd1);
    chk("brk_valid_cnt", 32'(vrise_cnt), 32'd0);

    // Overrun: 0x11 then 0x22 with ready low
    idle(4);
    clr_mon();
    rx_ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(LAT - 10);
    chk("ovr_before", 32'(rx_overrun_o), 32'h0);
    idle(1);
    chk("ovr_pulse", 32'(rx_overrun_o), 32'h1);
    idle(3);
    chk("ovr_cnt", 32'(ovr_cnt), 32'd1);
    chk("ovr_data", 32'(rx_data_o), 32'h11);
    chk("ovr_valid", 32'(rx_valid_o), 32'h1);
    chk("ovr_rises", 32'(vrise_cnt), 32'd1);

    // Reset during data bit 4 of 0xFF (valid still high from 0x11), then 0x81
    @(negedge clk_i) uart_rx_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i) uart_rx_i = 1'b1;
    end
    @(negedge clk_i) uart_rx_i = 1'b1;
    #1 resetn_i = 1'b0;
    #1;
    chk("mrst_data", 32'(rx_data_o), 32'h00);
    chk("mrst_valid", 32'(rx_valid_o), 32'h0);
    chk("mrst_busy", 32'(rx_busy_o), 32'h0);
    chk("mrst_err", 32'(rx_frame_err_o), 32'h0);
    chk("mrst_ovr", 32'(rx_overrun_o), 32'h0);
    @(negedge clk_i) resetn_i = 1'b1;
    rx_ready_i = 1'b1;
    clr_mon();
    idle(3);
    send_frame(8'h81, 1'b1);
    idle(LAT + 2);
    chk("mrst_rises", 32'(vrise_cnt), 32'd1);
    chk("mrst_rx", 32'(rise_data.size() > 0 ? rise_data[0] : 8'hxx), 32'h81);
    chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("data_stable", 32'(unstable_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
